// File: rtl/cpu_run_ctrl_if.sv
// Debug/host command port of the run controller: one command per cycle while
// cmd_valid is high, plus a one-cycle error pulse back to the host.
interface cpu_run_ctrl_if;
    logic        cmd_valid;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_arg;
    logic        cmd_err;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_arg,
        input  cmd_err
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_arg,
        output cmd_err
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step controller for a single-cycle RV32I core. It provides
// the commit enable, one hardware breakpoint, EBREAK halting and a retired-instruction count.
module cpu_run_ctrl #(
    parameter bit START_HALTED = 1'b0,
    parameter int CNT_W        = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    cpu_run_ctrl_if.slave        cmd,
    input  logic [31:0]          PC,
    input  logic [31:0]          Instr,
    output logic                 cpu_en,
    output logic                 halted,
    output logic [1:0]           halt_cause,
    output logic                 bp_active,
    output logic [CNT_W-1:0]     instret
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_STEP   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    localparam state_t     RESET_STATE = START_HALTED ? S_HALTED : S_RUN;
    localparam logic [31:0] EBREAK     = 32'h0010_0073;

    localparam logic [2:0] OP_HALT   = 3'b000;
    localparam logic [2:0] OP_RESUME = 3'b001;
    localparam logic [2:0] OP_STEP   = 3'b010;
    localparam logic [2:0] OP_SETBP  = 3'b011;
    localparam logic [2:0] OP_CLRBP  = 3'b100;

    localparam logic [1:0] CAUSE_CMD  = 2'b00;
    localparam logic [1:0] CAUSE_BP   = 2'b01;
    localparam logic [1:0] CAUSE_EB   = 2'b10;
    localparam logic [1:0] CAUSE_STEP = 2'b11;

    state_t             r_state;
    logic [1:0]         r_halt_cause;
    logic [CNT_W-1:0]   r_instret;
    logic               r_bp_active;
    logic [31:0]        r_bp_addr;
    logic [CNT_W-1:0]   r_step_rem;
    logic               r_skip;
    logic               r_cmd_err;

    state_t             w_state_next;
    logic [1:0]         w_cause_next;
    logic [CNT_W-1:0]   w_step_rem_next;

    logic w_hit_bp;
    logic w_hit_eb;
    logic w_cpu_en;
    logic w_executing;
    logic w_cmd_halt;
    logic w_cmd_resume;
    logic w_cmd_step;
    logic w_cmd_setbp;
    logic w_cmd_clrbp;
    logic w_resume_ok;
    logic w_step_ok;
    logic w_illegal;

    // skip masks the stop checks for the one instruction we were parked on.
    assign w_hit_bp    = r_bp_active && (PC == r_bp_addr) && !r_skip;
    assign w_hit_eb    = (Instr == EBREAK) && !r_skip;
    assign w_executing = (r_state == S_RUN) || (r_state == S_STEP);
    assign w_cpu_en    = w_executing && !w_hit_bp && !w_hit_eb;

    assign w_cmd_halt   = cmd.cmd_valid && (cmd.cmd_op == OP_HALT);
    assign w_cmd_resume = cmd.cmd_valid && (cmd.cmd_op == OP_RESUME);
    assign w_cmd_step   = cmd.cmd_valid && (cmd.cmd_op == OP_STEP);
    assign w_cmd_setbp  = cmd.cmd_valid && (cmd.cmd_op == OP_SETBP);
    assign w_cmd_clrbp  = cmd.cmd_valid && (cmd.cmd_op == OP_CLRBP);

    assign w_resume_ok = w_cmd_resume && !w_executing;
    assign w_step_ok   = w_cmd_step && !w_executing;
    assign w_illegal   = cmd.cmd_valid &&
                         (((w_cmd_resume || w_cmd_step) && w_executing) ||
                          (cmd.cmd_op > OP_CLRBP));

    always_comb begin
        w_state_next    = r_state;
        w_cause_next    = r_halt_cause;
        w_step_rem_next = r_step_rem;
        case (r_state)
            S_RUN: begin
                if (w_hit_bp) begin
                    w_state_next = S_HALTED;
                    w_cause_next = CAUSE_BP;
                end else if (w_hit_eb) begin
                    w_state_next = S_HALTED;
                    w_cause_next = CAUSE_EB;
                end else if (w_cmd_halt) begin
                    w_state_next = S_HALTED;
                    w_cause_next = CAUSE_CMD;
                end
            end
            S_STEP: begin
                if (w_cpu_en) begin
                    w_step_rem_next = r_step_rem - CNT_W'(1);
                end
                if (w_hit_bp) begin
                    w_state_next = S_HALTED;
                    w_cause_next = CAUSE_BP;
                end else if (w_hit_eb) begin
                    w_state_next = S_HALTED;
                    w_cause_next = CAUSE_EB;
                end else if (w_cpu_en && (r_step_rem == CNT_W'(1))) begin
                    w_state_next = S_HALTED;
                    w_cause_next = CAUSE_STEP;
                end else if (w_cmd_halt) begin
                    w_state_next = S_HALTED;
                    w_cause_next = CAUSE_CMD;
                end
            end
            S_HALTED: begin
                if (w_resume_ok) begin
                    w_state_next = S_RUN;
                end else if (w_step_ok) begin
                    // A zero count still executes one instruction.
                    w_state_next    = S_STEP;
                    w_step_rem_next = (cmd.cmd_arg == 32'd0) ? CNT_W'(1)
                                                             : CNT_W'(cmd.cmd_arg);
                end
            end
            default: begin
                w_state_next = S_HALTED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= RESET_STATE;
            r_halt_cause <= CAUSE_CMD;
            r_instret    <= '0;
            r_bp_active  <= 1'b0;
            r_bp_addr    <= 32'd0;
            r_step_rem   <= '0;
            r_skip       <= 1'b0;
            r_cmd_err    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_halt_cause <= w_cause_next;
            r_step_rem   <= w_step_rem_next;
            r_cmd_err    <= w_illegal;
            if (w_cpu_en) begin
                r_instret <= r_instret + CNT_W'(1);
            end
            if (w_resume_ok || w_step_ok) begin
                r_skip <= 1'b1;
            end else if (w_cpu_en) begin
                r_skip <= 1'b0;
            end
            if (w_cmd_setbp) begin
                r_bp_addr   <= cmd.cmd_arg;
                r_bp_active <= 1'b1;
            end else if (w_cmd_clrbp) begin
                r_bp_active <= 1'b0;
            end
        end
    end

    assign cpu_en      = w_cpu_en;
    assign halted      = (r_state == S_HALTED);
    assign halt_cause  = r_halt_cause;
    assign bp_active   = r_bp_active;
    assign instret     = r_instret;
    assign cmd.cmd_err = r_cmd_err;

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Run/halt/single-step controller for the single-cycle RV32I core.
- Produces one enable, cpu_en. The top level uses it to gate the PC register update, RegWrite and data-memory write, so the core freezes cleanly between instructions.
- Accepts commands from a debug/host port. Provides one hardware breakpoint, halts on EBREAK, and counts retired instructions.

Parameters:
- START_HALTED, 0: state entered on reset (0 = RUN, 1 = HALTED).
- CNT_W, 32: width of the retired-instruction counter and the step counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command strobe. Exactly one command is consumed per cycle while high.
- cmd_op  in  3  command: 000 HALT, 001 RESUME, 010 STEP, 011 SETBP, 100 CLRBP; 101-111 reserved.
- cmd_arg  in  32  STEP = instruction count; SETBP = breakpoint address.
- cmd_err  out  1  one-cycle pulse, cycle after an illegal or reserved command.
- PC  in  32  current PC from the datapath.
- Instr  in  32  current instruction from instruction memory.
- cpu_en  out  1  1 = the current instruction commits this cycle.
- halted  out  1  1 in HALTED state.
- halt_cause  out  2  00 command/reset, 01 breakpoint, 10 EBREAK, 11 step done.
- bp_active  out  1  breakpoint armed.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- **States:** RUN, STEP, HALTED; registered.
- **Reset values:**
  - state = HALTED if START_HALTED, else RUN.
  - halt_cause = 00; instret = 0; bp_active = 0; bp_addr = 0; step_rem = 0; skip = 0; cmd_err = 0.
  - Reset mid-step or mid-run aborts everything and applies these values.
- **Stop detection (combinational):**
  - hit_bp = bp_active && PC == bp_addr && !skip.
  - hit_eb = Instr == 32'h00100073 && !skip.
- **cpu_en (combinational):** cpu_en = (state is RUN or STEP) && !hit_bp && !hit_eb. A stopping instruction never commits.
- **instret:** increments by 1 every cycle cpu_en = 1 and wraps modulo 2^CNT_W.
- **skip:**
  - Set on an accepted RESUME or STEP.
  - Cleared on the first cycle cpu_en = 1.
  - Effect: resuming from a breakpoint or EBREAK executes that instruction once instead of re-halting.
- **RUN transitions:**
  - hit_bp → HALTED, cause 01.
  - Otherwise hit_eb → HALTED, cause 10.
  - Otherwise HALT command → HALTED, cause 00. The instruction in that cycle still commits.
- **STEP transitions:**
  - Same stop checks as RUN.
  - Each cpu_en = 1 cycle decrements step_rem. When step_rem is 1 and cpu_en = 1 → HALTED, cause 11.
  - HALT command → HALTED, cause 00.
- **HALTED transitions:**
  - RESUME → RUN.
  - STEP → STEP with step_rem = cmd_arg; cmd_arg = 0 is treated as 1.
- **Priority in one cycle:** breakpoint > EBREAK > step done > HALT command.
- **SETBP / CLRBP:**
  - Legal in any state.
  - SETBP sets bp_addr = cmd_arg and bp_active = 1; CLRBP sets bp_active = 0.
  - Both take effect the next cycle.
- **Illegal commands:**
  - RESUME or STEP while in RUN or STEP, and all reserved ops.
  - No state change; cmd_err pulses high the next cycle for one cycle.
- **Outputs:**
  - halted = (state == HALTED).
  - halt_cause holds until the next HALTED entry. It is not cleared by RESUME.
- **Core contract:** in HALTED, PC is static, so the controller needs no PC capture.
- **Latency:** a command takes effect on the cycle after cmd_valid.

Test Plan:
1. **Reset and basic run.** Reset with START_HALTED=0, run 10 non-EBREAK instructions → cpu_en=1 throughout, instret=10, halted=0, halt_cause=00.
2. **Breakpoint and resume.** SETBP 0x0000_0020, run from PC 0 → halt with PC=0x20, cpu_en=0 in the hit cycle, halt_cause=01, instret=8. Then RESUME → the 0x20 instruction commits, run continues, and the core re-halts only on the next arrival at 0x20.
3. **Step counts.**
   - From HALTED, STEP arg=3 → exactly 3 cpu_en=1 cycles, then halted=1, halt_cause=11, instret +3.
   - STEP arg=0 → exactly 1 instruction.
4. **EBREAK.** Instr=0x00100073 at PC 0x40 → cpu_en=0, HALTED, halt_cause=10. A following STEP 1 commits the EBREAK and halts with cause 11.
5. **Simultaneous events and illegal commands.**
   - HALT command in the same cycle as a breakpoint hit → halt_cause=01, and the instruction does not commit.
   - RESUME while RUN → cmd_err pulse, state unchanged.
   - op 111 → cmd_err pulse.
6. **Reset mid-step.** STEP arg=5, assert reset after 2 instructions → next cycle: state RUN, instret=0, bp_active=0, cpu_en=1.
